apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester_if.sv | 53 +++++
 rtl/apb_requester.sv | 136 +++++++++++++
 tb/tb_apb_requester.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// Command, response and APB bus signals of the APB requester.
// The master modport is the requester's view; the slave modport is the environment's view.
interface apb_requester_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB bus
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: turns one command into one SETUP/ACCESS transfer
// and returns one response. All outputs are registered except cmd_ready.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            pclk,
  input  logic            presetn,
  apb_requester_if.master bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic cmd_ready;
  logic cmd_accept;

  // A new command may enter only when the previous response is gone or leaving this edge.
  assign cmd_ready  = (state_q == StIdle) && (!rsp_valid_q || bus.rsp_ready);
  assign cmd_accept = bus.cmd_valid && cmd_ready;

  // State and registered outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (bus.pready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next-values
  always_comb begin
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          paddr_d   = bus.cmd_addr;
          pprot_d   = bus.cmd_prot;
          pwrite_d  = bus.cmd_write;
          // Reads drive no write data or strobes on the bus.
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
      end
      StAccess: begin
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.paddr     = paddr_q;
  assign bus.pprot     = pprot_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_apb_requester;
  logic pclk;
  logic presetn;
  int   vectors;
  int   miscompares;

  apb_requester_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  apb_requester #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic s, input logic [2:0] p);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    presetn     = 1'b0;
    set_cmd(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    bus.prdata    = 8'h00;
    bus.pslverr   = 1'b0;

    // Reset state
    #12;
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_paddr", 32'(bus.paddr), 0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 0);
    @(negedge pclk);
    presetn = 1'b1;
    step();
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // Write, zero wait states, pready tied high
    bus.pready = 1'b1;
    set_cmd(1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 3'd2);
    step();
    bus.cmd_valid = 1'b0;
    chk("wr_setup_psel", 32'(bus.psel), 1);
    chk("wr_setup_penable", 32'(bus.penable), 0);
    chk("wr_setup_paddr", 32'(bus.paddr), 5);
    chk("wr_setup_pwdata", 32'(bus.pwdata), 32'hA5);
    chk("wr_setup_pstrb", 32'(bus.pstrb), 1);
    chk("wr_setup_pprot", 32'(bus.pprot), 2);
    chk("wr_setup_pwrite", 32'(bus.pwrite), 1);
    chk("wr_setup_cmd_ready", 32'(bus.cmd_ready), 0);
    step();
    chk("wr_access_penable", 32'(bus.penable), 1);
    chk("wr_access_rsp_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 0);
    chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("wr_done_psel", 32'(bus.psel), 0);
    chk("wr_done_penable", 32'(bus.penable), 0);
    step();
    chk("wr_rsp_cleared", 32'(bus.rsp_valid), 0);
    chk("idle_paddr_held", 32'(bus.paddr), 5);
    chk("idle_pwdata_held", 32'(bus.pwdata), 32'hA5);

    // Read with 3 wait states
    bus.pready = 1'b0;
    bus.prdata = 8'h3C;
    set_cmd(1'b1, 1'b0, 3'd2, 8'hFF, 1'b1, 3'd0);
    step();
    bus.cmd_valid = 1'b0;
    chk("rd_setup_paddr", 32'(bus.paddr), 2);
    chk("rd_setup_pwdata", 32'(bus.pwdata), 0);
    chk("rd_setup_pstrb", 32'(bus.pstrb), 0);
    chk("rd_setup_pwrite", 32'(bus.pwrite), 0);
    step();
    chk("rd_access1_penable", 32'(bus.penable), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_wait_penable", 32'(bus.penable), 1);
      chk("rd_wait_psel", 32'(bus.psel), 1);
      chk("rd_wait_paddr", 32'(bus.paddr), 2);
      chk("rd_wait_rsp_valid", 32'(bus.rsp_valid), 0);
    end
    bus.pready = 1'b1;
    step();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
    chk("rd_rsp_err", 32'(bus.rsp_err), 0);
    chk("rd_done_psel", 32'(bus.psel), 0);

    // Error response, issued back-to-back with the previous response handshake
    bus.pslverr = 1'b1;
    bus.prdata  = 8'h77;
    set_cmd(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 3'd0);
    chk("err_cmd_ready", 32'(bus.cmd_ready), 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("err_setup_psel", 32'(bus.psel), 1);
    chk("err_prev_rsp_cleared", 32'(bus.rsp_valid), 0);
    step();
    step();
    chk("err_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("err_rsp_err", 32'(bus.rsp_err), 1);
    chk("err_rsp_rdata", 32'(bus.rsp_rdata), 32'h77);
    bus.pslverr = 1'b0;
    bus.prdata  = 8'h12;
    set_cmd(1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 3'd0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("ok_rsp_err", 32'(bus.rsp_err), 0);
    chk("ok_rsp_rdata", 32'(bus.rsp_rdata), 32'h12);

    // Response backpressure
    bus.rsp_ready = 1'b0;
    set_cmd(1'b1, 1'b1, 3'd6, 8'h5A, 1'b1, 3'd1);
    #1;
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("bp_hold_psel", 32'(bus.psel), 0);
      chk("bp_hold_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_rsp_rdata", 32'(bus.rsp_rdata), 32'h12);
      chk("bp_hold_paddr", 32'(bus.paddr), 3);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_cmd_ready", 32'(bus.cmd_ready), 1);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_accept_psel", 32'(bus.psel), 1);
    chk("bp_accept_paddr", 32'(bus.paddr), 6);
    chk("bp_accept_rsp_cleared", 32'(bus.rsp_valid), 0);
    step();
    step();
    chk("bp_wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_wr_rsp_rdata", 32'(bus.rsp_rdata), 0);

    // Four back-to-back writes, one every 3 cycles
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 3'd0);
      chk("b2b_cmd_ready", 32'(bus.cmd_ready), 1);
      step();
      chk("b2b_setup_psel", 32'(bus.psel), 1);
      chk("b2b_setup_penable", 32'(bus.penable), 0);
      chk("b2b_setup_paddr", 32'(bus.paddr), 32'(i));
      chk("b2b_setup_pwdata", 32'(bus.pwdata), 32'(8'h10 + i));
      chk("b2b_setup_rsp_valid", 32'(bus.rsp_valid), 0);
      step();
      chk("b2b_access_penable", 32'(bus.penable), 1);
      step();
      chk("b2b_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("b2b_done_psel", 32'(bus.psel), 0);
    end
    bus.cmd_valid = 1'b0;
    step();
    chk("b2b_rsp_cleared", 32'(bus.rsp_valid), 0);

    // Reset asserted mid-ACCESS
    bus.pready = 1'b0;
    set_cmd(1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 3'd0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("mid_rst_penable_before", 32'(bus.penable), 1);
    #2;
    presetn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(bus.psel), 0);
    chk("mid_rst_penable", 32'(bus.penable), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_paddr", 32'(bus.paddr), 0);
    bus.pready = 1'b1;
    @(negedge pclk);
    bus.pready = 1'b0;
    presetn    = 1'b1;
    step();
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 0);
    step();
    chk("mid_rst_still_no_rsp", 32'(bus.rsp_valid), 0);
    chk("mid_rst_idle_psel", 32'(bus.psel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
